my_pe_ctrl: RTL and testbench
=============================

Name: my_pe_ctrl

Overview:
- Sequencer that sits directly upstream of one my_pe processing element.
- Loads a weight vector into the PE local RAM and buffers an activation vector.
- Issues the activations to the PE MAC so that each issue lands in the cycle the previous partial sum is valid, then returns the dot product on a ready/valid result port.
- Watchdog flags a missing MAC response.

Parameters:
- VECTOR_SIZE, 16, elements per dot product and PE RAM depth (>=2).
- TIMEOUT, 64, max cycles to wait for pe_dvalid after an issue.

Ports:
- aclk  in  1  clock; all state updates on rising edge.
- areset  in  1  synchronous active-high reset.
- start  in  1  one-cycle job request; sampled only in IDLE.
- load_w  in  1  sampled with start; 1 = reload weights before compute.
- busy  out  1  high in every state except IDLE.
- w_valid  in  1  weight beat valid.
- w_ready  out  1  high only in LOAD_W.
- w_data  in  32  FP32 weight.
- x_valid  in  1  activation beat valid.
- x_ready  out  1  high only in LOAD_X.
- x_data  in  32  FP32 activation.
- pe_ain  out  32  to PE ain.
- pe_din  out  32  to PE din.
- pe_addr  out  32  to PE addr, zero-extended index.
- pe_we  out  1  to PE we.
- pe_valid  out  1  to PE valid.
- pe_dvalid  in  1  from PE dvalid.
- pe_dout  in  32  from PE dout.
- m_valid  out  1  result valid.
- m_ready  in  1  result accepted.
- m_data  out  32  FP32 dot product.
- m_err  out  1  timeout flag, qualified by m_valid.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset, including mid-job: state=IDLE; counters, m_data, m_err, xbuf cleared; all outputs 0; any in-flight PE result is ignored.
- States: IDLE, LOAD_W, LOAD_X, PRIME, ISSUE, WAIT, RESULT.
- IDLE:
  - start&load_w -> LOAD_W.
  - start&!load_w -> LOAD_X, reusing the weights already in PE RAM.
  - m_err cleared on start.
- LOAD_W:
  - Each w_valid&w_ready beat drives pe_we=1, pe_addr=idx, pe_din=w_data, combinationally in the same cycle; idx++.
  - After beat VECTOR_SIZE-1 -> LOAD_X, idx=0.
  - pe_we=0 at all other times.
- LOAD_X: each x_valid&x_ready beat stores xbuf[idx]; after the last beat -> PRIME, k=0.
- PRIME: one cycle with pe_we=0, pe_addr=0, so the PE latches weight[0] on the falling edge.
- ISSUE:
  - pe_valid=1, pe_ain=xbuf[0] for exactly one cycle.
  - pe_dvalid is 0 here, so PE psum=0; this is the required zero seed.
  - pe_addr becomes 1 (k=1) -> WAIT; watchdog cleared.
- WAIT:
  - pe_addr=k is held, so the weight for the next issue is latched before it is needed.
  - On pe_dvalid with k<VECTOR_SIZE: pe_valid=1 and pe_ain=xbuf[k], combinational in the same cycle, so the MAC c operand picks up the live psum; k++; pe_addr follows; watchdog cleared.
  - On pe_dvalid with k==VECTOR_SIZE: m_data<=pe_dout -> RESULT.
  - Watchdog reaching TIMEOUT with no pe_dvalid: m_err<=1, m_data<=0 -> RESULT.
- Exactly VECTOR_SIZE pe_valid pulses per job, never two in consecutive cycles unless pe_dvalid is asserted in the second.
- RESULT:
  - m_valid=1; m_data and m_err held stable until m_ready -> IDLE.
  - A start in RESULT is ignored.
- Stray pe_dvalid in any state other than WAIT: ignored.
- pe_din and pe_ain are 0 when not driven.
- No FP arithmetic in this block; the data path is pass-through/buffer only.

Decomposition:
- Shared package holds:
  - state enum;
  - FP32 width constant 32;
  - index width $clog2(VECTOR_SIZE+1);
  - FP32 constants ONE=0x3F800000, TWO=0x40000000.
- Sub-module my_pe_xbuf: VECTOR_SIZE x 32 register file with one write port and one combinational read port.
- FSM and watchdog stay in the top level.
- The bench instantiates my_pe_ctrl with the real my_pe.

Test Plan:
- Scenario 1, basic dot product: load_w=1, all weights 0x3F800000, all x 0x40000000, VECTOR_SIZE=16 -> m_data=0x42000000 (32.0), m_err=0, exactly 16 pe_valid pulses.
- Scenario 2, weight reuse: rerun with load_w=0 and x=0x3F800000 -> m_data=0x41800000 (16.0); pe_we never asserted.
- Scenario 3, backpressure: w_valid/x_valid toggled randomly, m_ready held low 10 cycles -> same result as scenario 1; m_data stable while stalled.
- Scenario 4, timeout: PE replaced by a stub that never asserts dvalid -> m_valid with m_err=1, m_data=0, 64 cycles after the issue.
- Scenario 5, reset mid-job: areset pulsed in WAIT -> next cycle busy=0, m_valid=0, pe_valid=0; a following full job gives the correct 32.0.
- Scenario 6, start in RESULT: start pulsed while in RESULT -> ignored; state returns to IDLE only on m_ready.

Source files
------------

// File: rtl/my_pe_ctrl_pkg.sv
// my_pe_ctrl_pkg: shared state enum, FP32 width/constants and index width helper
package my_pe_ctrl_pkg;
  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] FP_ONE = 32'h3F80_0000;
  localparam logic [FP_W-1:0] FP_TWO = 32'h4000_0000;
  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_X, PRIME, ISSUE, WAIT, RESULT} state_e;
  function automatic int idx_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/my_pe_xbuf.sv
// my_pe_xbuf: activation register file, one write port, one combinational read port
module my_pe_xbuf
  import my_pe_ctrl_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [FP_W-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [FP_W-1:0] rdata
);
  logic [FP_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    else if (we) mem_q[waddr] <= wdata;
  end
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/my_pe_ctrl.sv
// my_pe_ctrl: loads PE weights, buffers activations, paces MAC issues on pe_dvalid and returns the dot product
module my_pe_ctrl
  import my_pe_ctrl_pkg::*;
#(
  parameter int VECTOR_SIZE = 16,
  parameter int TIMEOUT = 64
) (
  input  logic            aclk,
  input  logic            areset,
  input  logic            start,
  input  logic            load_w,
  output logic            busy,
  input  logic            w_valid,
  output logic            w_ready,
  input  logic [FP_W-1:0] w_data,
  input  logic            x_valid,
  output logic            x_ready,
  input  logic [FP_W-1:0] x_data,
  output logic [FP_W-1:0] pe_ain,
  output logic [FP_W-1:0] pe_din,
  output logic [31:0]     pe_addr,
  output logic            pe_we,
  output logic            pe_valid,
  input  logic            pe_dvalid,
  input  logic [FP_W-1:0] pe_dout,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [FP_W-1:0] m_data,
  output logic            m_err
);
  localparam int IW = idx_w(VECTOR_SIZE);
  localparam int AW = $clog2(VECTOR_SIZE);
  localparam int WW = $clog2(TIMEOUT + 1);
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [FP_W-1:0] m_data_q, m_data_d, x_rd;
  logic m_err_q, m_err_d, xbuf_we;
  my_pe_xbuf #(.DEPTH(VECTOR_SIZE), .AW(AW)) u_xbuf (
    .clk(aclk),
    .rst(areset),
    .we(xbuf_we),
    .waddr(idx_q[AW-1:0]),
    .wdata(x_data),
    .raddr(idx_q[AW-1:0]),
    .rdata(x_rd)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    wd_d = wd_q;
    m_data_d = m_data_q;
    m_err_d = m_err_q;
    xbuf_we = 1'b0;
    pe_we = 1'b0;
    pe_valid = 1'b0;
    pe_din = '0;
    pe_ain = '0;
    pe_addr = '0;
    unique case (state_q)
      IDLE: if (start) begin
        m_err_d = 1'b0;
        idx_d = '0;
        state_d = load_w ? LOAD_W : LOAD_X;
      end
      LOAD_W: begin
        pe_addr = 32'(idx_q);
        if (w_valid) begin
          pe_we = 1'b1;
          pe_din = w_data;
          idx_d = (idx_q == IW'(VECTOR_SIZE - 1)) ? '0 : idx_q + 1'b1;
          state_d = (idx_q == IW'(VECTOR_SIZE - 1)) ? LOAD_X : LOAD_W;
        end
      end
      LOAD_X: if (x_valid) begin
        xbuf_we = 1'b1;
        idx_d = (idx_q == IW'(VECTOR_SIZE - 1)) ? '0 : idx_q + 1'b1;
        state_d = (idx_q == IW'(VECTOR_SIZE - 1)) ? PRIME : LOAD_X;
      end
      PRIME: state_d = ISSUE;
      ISSUE: begin
        pe_valid = 1'b1;
        pe_ain = x_rd;
        idx_d = IW'(1);
        wd_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // addr k is presented for a whole cycle so the PE latches weight[k] before the issue edge
        pe_addr = 32'(idx_q);
        if (pe_dvalid && idx_q == IW'(VECTOR_SIZE)) begin
          m_data_d = pe_dout;
          state_d = RESULT;
        end else if (pe_dvalid) begin
          pe_valid = 1'b1;
          pe_ain = x_rd;
          idx_d = idx_q + 1'b1;
          wd_d = '0;
        end else if (wd_q == WW'(TIMEOUT - 1)) begin
          m_err_d = 1'b1;
          m_data_d = '0;
          state_d = RESULT;
        end else wd_d = wd_q + 1'b1;
      end
      RESULT: state_d = m_ready ? IDLE : RESULT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      idx_q <= '0;
      wd_q <= '0;
      m_data_q <= '0;
      m_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      wd_q <= wd_d;
      m_data_q <= m_data_d;
      m_err_q <= m_err_d;
    end
  end
  assign busy = state_q != IDLE;
  assign w_ready = state_q == LOAD_W;
  assign x_ready = state_q == LOAD_X;
  assign m_valid = state_q == RESULT;
  assign m_data = m_data_q;
  assign m_err = m_err_q;
endmodule

// File: tb/tb_my_pe_ctrl.sv
// tb_my_pe_ctrl: table-driven check of my_pe_ctrl against a behavioural PE model
module tb_my_pe_ctrl;
  import my_pe_ctrl_pkg::*;
  localparam int VS = 16;
  localparam int TO = 64;
  localparam int LAT = 3;
  logic aclk = 0, areset = 1, start = 0, load_w = 0, w_valid = 0, x_valid = 0, m_ready = 0;
  logic [31:0] w_data = 0, x_data = 0, pe_dout, pe_ain, pe_din, pe_addr, m_data;
  logic busy, w_ready, x_ready, pe_we, pe_valid, pe_dvalid, m_valid, m_err;
  int checks = 0, errors = 0;
  always #5 aclk = ~aclk;
  my_pe_ctrl #(.VECTOR_SIZE(VS), .TIMEOUT(TO)) dut (
    .aclk(aclk), .areset(areset), .start(start), .load_w(load_w), .busy(busy),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .pe_ain(pe_ain), .pe_din(pe_din), .pe_addr(pe_addr), .pe_we(pe_we),
    .pe_valid(pe_valid), .pe_dvalid(pe_dvalid), .pe_dout(pe_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_err(m_err)
  );
  function automatic real fp2r(input logic [31:0] b);
    real m;
    int e;
    if (b[30:0] == 0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    for (int i = 0; i < e; i++) m = m * 2.0;
    for (int i = 0; i > e; i--) m = m / 2.0;
    return b[31] ? -m : m;
  endfunction
  function automatic logic [31:0] r2fp(input real r);
    int e;
    logic s;
    if (r == 0.0) return 32'h0;
    s = r < 0.0;
    if (s) r = -r;
    e = 127;
    while (r >= 2.0) begin r = r / 2.0; e++; end
    while (r < 1.0) begin r = r * 2.0; e--; end
    return {s, 8'(e), 23'($rtoi((r - 1.0) * 8388608.0))};
  endfunction
  // PE model: weight latched on the falling edge, MAC c operand = live psum when dvalid, LAT-cycle result
  logic [31:0] pe_ram [VS];
  logic [31:0] w_lat;
  logic [31:0] dat_sr [LAT];
  logic [LAT-1:0] vld_sr = '0;
  logic stub_dead = 0;
  assign pe_dvalid = vld_sr[LAT-1] & ~stub_dead;
  assign pe_dout = dat_sr[LAT-1];
  always @(negedge aclk) w_lat <= pe_ram[pe_addr[3:0]];
  always @(posedge aclk) begin
    if (pe_we) pe_ram[pe_addr[3:0]] <= pe_din;
    vld_sr <= {vld_sr[LAT-2:0], pe_valid};
    dat_sr[0] <= pe_valid ? r2fp(fp2r(pe_ain) * fp2r(w_lat) + (pe_dvalid ? fp2r(pe_dout) : 0.0)) : 32'h0;
    for (int i = 1; i < LAT; i++) dat_sr[i] <= dat_sr[i-1];
  end
  int pulses = 0, we_cnt = 0, viol = 0;
  logic prev_v = 0;
  always @(negedge aclk) begin
    if (pe_valid === 1'b1) pulses++;
    if (pe_we === 1'b1) we_cnt++;
    if (prev_v && pe_valid === 1'b1 && pe_dvalid !== 1'b1) viol++;
    prev_v = pe_valid === 1'b1;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask
  typedef struct {
    logic lw;
    logic [31:0] w, x, exp_d;
    logic exp_e;
    int bp, stall, poke, dead, exp_p, exp_we;
  } vec_t;
  vec_t tbl [6];
  task automatic run_job(input int id, input vec_t v);
    int p0, w0, v0, n, since;
    string s;
    s = $sformatf("job%0d", id);
    p0 = pulses; w0 = we_cnt; v0 = viol; n = 0; since = 0;
    stub_dead = v.dead[0];
    @(negedge aclk);
    start = 1; load_w = v.lw;
    @(negedge aclk);
    start = 0; load_w = 0;
    chk({s, "_busy"}, 32'(busy), 32'd1);
    while (n < 2000) begin
      w_valid = v.bp != 0 ? 1'($urandom % 2) : 1'b1;
      x_valid = v.bp != 0 ? 1'($urandom % 2) : 1'b1;
      w_data = v.w; x_data = v.x;
      @(negedge aclk);
      n++;
      if (m_valid) break;
      since = pe_valid ? 0 : since + 1;
    end
    w_valid = 0; x_valid = 0;
    chk({s, "_m_valid"}, 32'(m_valid), 32'd1);
    chk({s, "_data"}, m_data, v.exp_d);
    chk({s, "_err"}, 32'(m_err), 32'(v.exp_e));
    chk({s, "_pulses"}, 32'(pulses - p0), 32'(v.exp_p));
    chk({s, "_we"}, 32'(we_cnt - w0), 32'(v.exp_we));
    chk({s, "_b2b"}, 32'(viol - v0), 32'd0);
    // the watchdog trips on the TIMEOUT-th WAIT cycle without dvalid
    if (v.dead != 0) chk({s, "_wait_cycles"}, 32'(since), 32'(TO));
    for (int i = 0; i < v.stall; i++) begin
      start = v.poke != 0 && i == 2;
      @(negedge aclk);
      chk({s, "_stall_valid"}, 32'(m_valid), 32'd1);
      chk({s, "_stall_data"}, m_data, v.exp_d);
    end
    start = 0; m_ready = 1;
    @(negedge aclk);
    m_ready = 0;
    chk({s, "_idle_busy"}, 32'(busy), 32'd0);
    chk({s, "_idle_valid"}, 32'(m_valid), 32'd0);
    if (v.poke != 0) begin
      repeat (3) @(negedge aclk);
      chk({s, "_poke_ignored"}, {30'd0, busy, w_ready}, 32'd0);
    end
    stub_dead = 0;
  endtask
  initial begin
    int p0, n;
    tbl[0] = '{lw:1, w:FP_ONE, x:FP_TWO, exp_d:32'h4200_0000, exp_e:0, bp:0, stall:0, poke:0, dead:0, exp_p:VS, exp_we:VS};
    tbl[1] = '{lw:0, w:FP_ONE, x:FP_ONE, exp_d:32'h4180_0000, exp_e:0, bp:0, stall:0, poke:0, dead:0, exp_p:VS, exp_we:0};
    tbl[2] = '{lw:1, w:FP_ONE, x:FP_TWO, exp_d:32'h4200_0000, exp_e:0, bp:1, stall:10, poke:1, dead:0, exp_p:VS, exp_we:VS};
    tbl[3] = '{lw:1, w:FP_TWO, x:FP_TWO, exp_d:32'h4280_0000, exp_e:0, bp:0, stall:0, poke:0, dead:0, exp_p:VS, exp_we:VS};
    tbl[4] = '{lw:0, w:FP_ONE, x:FP_ONE, exp_d:32'h4200_0000, exp_e:0, bp:1, stall:2, poke:0, dead:0, exp_p:VS, exp_we:0};
    tbl[5] = '{lw:0, w:FP_ONE, x:FP_TWO, exp_d:32'h0, exp_e:1, bp:0, stall:3, poke:0, dead:1, exp_p:1, exp_we:0};
    repeat (3) @(negedge aclk);
    chk("rst_status", {26'd0, busy, w_ready, x_ready, m_valid, m_err, pe_valid}, 32'd0);
    chk("rst_pe_we", 32'(pe_we), 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_pe_addr", pe_addr, 32'd0);
    chk("rst_pe_ain_din", pe_ain | pe_din, 32'd0);
    areset = 0;
    @(negedge aclk);
    chk("idle_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) run_job(i, tbl[i]);
    p0 = pulses; n = 0;
    start = 1; load_w = 1;
    @(negedge aclk);
    start = 0; load_w = 0; w_valid = 1; x_valid = 1; w_data = FP_ONE; x_data = FP_TWO;
    while (n < 500 && !(pulses - p0 >= 3 && !pe_valid)) begin @(negedge aclk); n++; end
    chk("midjob_reached_wait", 32'(pulses - p0 >= 3), 32'd1);
    w_valid = 0; x_valid = 0; areset = 1;
    @(negedge aclk);
    areset = 0;
    chk("midjob_rst", {29'd0, busy, m_valid, pe_valid}, 32'd0);
    repeat (4) @(negedge aclk);
    chk("midjob_stray_dvalid", {30'd0, busy, m_valid}, 32'd0);
    run_job(6, tbl[0]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    errors++;
    $display("FAIL global_timeout: got no finish expected finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "bench timeout");
  end
endmodule
